// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the fetched word for the decoder and selects the next PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr_out,
    output logic [5:0]       opcode,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic             retire,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Wide enough to hold TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       pc_r;
    logic [31:0]       instr_r;
    logic              valid_r;
    logic              req_r;
    logic              fault_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [TW-1:0]     tcnt_r;

    logic              ack_take_s;
    logic              retire_take_s;
    logic              tick_s;
    logic [31:0]       pc_plus4_s;
    logic [31:0]       next_pc_s;

    // Jump target: upper nibble of pc+4 with the 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] ins);
        return {pc4[31:28], ins[25:0], 2'b00};
    endfunction

    // Branch target: pc+4 plus the sign-extended word offset, modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [31:0] ins);
        return pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    endfunction

    assign pc_plus4_s  = pc_r + 32'd4;

    assign imem_req    = req_r;
    assign imem_addr   = {pc_r[31:2], 2'b00};
    assign instr_valid = valid_r;
    assign instr_out   = instr_r;
    assign opcode      = instr_r[31:26];
    assign pc_out      = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fault       = fault_r;
    assign instr_count = cnt_r;

    // Next-PC priority: jump, then taken branch, then sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (jump) begin
            next_pc_s = jump_target(pc_plus4_s, instr_r);
        end else if (branch && zero) begin
            next_pc_s = branch_target(pc_plus4_s, instr_r);
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Next-state and event decode; an ack is only taken while fetching and a
    // retire only while executing, everything else is ignored.
    always_comb begin
        state_s       = state_r;
        ack_take_s    = 1'b0;
        retire_take_s = 1'b0;
        tick_s        = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (imem_ack) begin
                    ack_take_s = 1'b1;
                    state_s    = S_EXEC;
                end else if (req_r) begin
                    if (tcnt_r == TW'(TIMEOUT - 1)) begin
                        state_s = S_FAULT;
                    end else begin
                        tick_s  = 1'b1;
                    end
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    retire_take_s = 1'b1;
                    state_s       = S_FETCH;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_FAULT: begin
                state_s = S_FAULT;
            end
            default: begin
                state_s = S_FAULT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered handshake and status outputs, derived from the next state so
    // they line up with it; req rises on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            req_r   <= (state_s == S_FETCH);
            fault_r <= (state_s == S_FAULT);
        end
    end

    // Instruction register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (ack_take_s) begin
            instr_r <= imem_rdata;
            valid_r <= 1'b1;
        end else if (retire_take_s) begin
            valid_r <= 1'b0;
        end
    end

    // PC and retired-instruction counter advance together on retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r  <= RESET_PC;
            cnt_r <= '0;
        end else if (retire_take_s) begin
            pc_r  <= next_pc_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Fetch timeout counter: counts unanswered request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= '0;
        end else if (retire_take_s) begin
            tcnt_r <= '0;
        end else if (tick_s) begin
            tcnt_r <= tcnt_r + TW'(1);
        end
    end

endmodule
